// File: rtl/uart_rx_to_mem.sv
// UART receiver that writes each good byte into a sequential operand-memory slot,
// wrapping after DEPTH words and flagging framing errors.
`timescale 1ns/1ps
module uart_rx_to_mem #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH        = 18,
    parameter int unsigned ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_mat,
    input  logic              rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              load_done,
    output logic              frame_err,
    output logic              rx_status
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              meta_q, sync_q, prev_q;
    logic [1:0]        settle_q;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              load_done_q, load_done_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_status_q, rx_status_d;
    logic              start_edge;

    // Edge history only counts once the synchronizer holds real line samples,
    // so a line that is already low when reset lifts never looks like a start bit.
    assign start_edge = settle_q[1] & prev_q & ~sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            count_q     <= '0;
            meta_q      <= 1'b1;
            sync_q      <= 1'b1;
            prev_q      <= 1'b0;
            settle_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            rx_status_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            count_q     <= count_d;
            meta_q      <= rx_data;
            sync_q      <= meta_q;
            prev_q      <= settle_q[1] ? sync_q : 1'b0;
            settle_q    <= {settle_q[0], 1'b1};
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
            rx_status_q <= rx_status_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        byte_d      = byte_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        frame_err_d = 1'b0;
        load_done_d = mem_we_q && (mem_addr_q == WORD_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    byte_d = {sync_q, byte_q[7:1]};
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (sync_q) begin
                        state_d = WRITE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            WRITE: begin
                cnt_d   = '0;
                state_d = IDLE;
                if (write_mat) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q;
                    mem_wdata_d = byte_q;
                    count_d     = (count_q == WORD_LAST) ? '0 : count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping write_mat restarts the next load from address 0.
        if (!write_mat) count_d = '0;
        rx_status_d = (state_d != IDLE);
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;
    assign rx_status = rx_status_q;
endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Scoreboard bench for uart_rx_to_mem: stimulus queues expected writes/pulses,
// a negedge monitor pops and compares whenever the DUT strobes an output.
`timescale 1ns/1ps
module tb_uart_rx_to_mem;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 18;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_mat;
    logic          rx_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          load_done;
    logic          frame_err;
    logic          rx_status;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           wr_q[$];
    wr_t           mon_e;
    int            pend_ld = 0;
    int            pend_fe = 0;
    int            checks  = 0;
    int            passes  = 0;
    int            cyc     = 0;
    int            last_we_cyc = 0;
    int            exp_addr = 0;
    int            start_cyc;
    int            lat;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    uart_rx_to_mem #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_mat (write_mat),
        .rx_data   (rx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .load_done (load_done),
        .frame_err (frame_err),
        .rx_status (rx_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every DUT strobe must match the head of the matching queue.
    always @(negedge clk) begin
        if (!rst) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                last_we_cyc = cyc;
                chk("we_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    mon_e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(mon_e.data));
                end
            end
            if (load_done) begin
                chk("ld_expected", 32'(pend_ld != 0), 32'd1);
                chk("ld_after_last_write", 32'(prev_we && (prev_addr == AW'(DEPTH - 1))), 32'd1);
                if (pend_ld != 0) pend_ld--;
            end
            if (frame_err) begin
                chk("fe_expected", 32'(pend_fe != 0), 32'd1);
                if (pend_fe != 0) pend_fe--;
            end
            prev_we   = mem_we;
            prev_addr = mem_addr;
        end
    end

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        rx_data = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        hold_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] d);
        wr_t w;
        if (write_mat) begin
            w.addr = AW'(exp_addr);
            w.data = d;
            wr_q.push_back(w);
            if (exp_addr == DEPTH - 1) begin
                pend_ld++;
                exp_addr = 0;
            end else begin
                exp_addr++;
            end
        end
        send_frame(d, 1'b1);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((wr_q.size() != 0 || pend_ld != 0 || pend_fe != 0) && i < 400) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        chk(name, 32'(wr_q.size()) + 32'(pend_ld) + 32'(pend_fe), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_rx_status"}, 32'(rx_status), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        write_mat = 1'b0;
        rx_data   = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst       = 1'b1;
        write_mat = 1'b1;
        idle(20);

        // Single byte, latency and busy flag
        start_cyc = cyc;
        fork
            send_byte(8'hA5);
            begin
                repeat (40) @(negedge clk);
                chk("rx_status_busy", 32'(rx_status), 32'd1);
            end
        join
        drain("single_drained");
        lat = last_we_cyc - start_cyc;
        chk("latency_window", 32'(lat >= 154 && lat <= 156), 32'd1);
        chk("idle_rx_status", 32'(rx_status), 32'd0);

        // Clear the word count, then a full back-to-back load plus one wrap byte
        write_mat = 1'b0;
        exp_addr  = 0;
        idle(4);
        write_mat = 1'b1;
        idle(4);
        for (int i = 1; i <= 19; i++) send_byte(8'(i));
        drain("full_load_drained");
        chk("hold_addr", 32'(mem_addr), 32'd0);
        chk("hold_data", 32'(mem_wdata), 32'h13);

        // Framing error, then the next good byte lands at the same address
        pend_fe++;
        send_frame(8'h3C, 1'b0);
        idle(16);
        drain("frame_err_drained");
        send_byte(8'h55);
        drain("after_fe_drained");

        // Glitch shorter than half a bit
        rx_data = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        chk("glitch_rx_status", 32'(rx_status), 32'd0);
        drain("glitch_quiet");

        // Abort mid-load: byte with write_mat low is dropped, next load starts at 0
        for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i));
        drain("abort_pre_drained");
        write_mat = 1'b0;
        exp_addr  = 0;
        idle(4);
        send_byte(8'hEE);
        drain("dropped_quiet");
        write_mat = 1'b1;
        idle(4);
        send_byte(8'h77);
        drain("abort_drained");

        // Reset during DATA of 0x99, line held low across release
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b0);
        chk("busy_before_rst", 32'(rx_status), 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("low_line_ignored", 32'(rx_status), 32'd0);
        idle(20);
        send_byte(8'h42);
        drain("post_rst_drained");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_to_mem.md
UART_RX_TO_MEM -- requirements
Module: uart_rx_to_mem

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 8..65535.
REQ-002 Parameter DEPTH, default 18, words per matrix load (two 3x3 8-bit operand matrices).
REQ-003 Parameter ADDR_W, default 5, memory address width; 2^ADDR_W >= DEPTH.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 write_mat  input  1  level enable; high permits writes to memory, low discards bytes and clears the address counter.
REQ-007 rx_data  input  1  UART serial in, idle high, asynchronous to clk.
REQ-008 mem_we  output  1  one-cycle write strobe to operand memory.
REQ-009 mem_addr  output  ADDR_W  write address, valid when mem_we=1.
REQ-010 mem_wdata  output  8  received byte, valid when mem_we=1.
REQ-011 load_done  output  1  one-cycle pulse after DEPTH words have been written.
REQ-012 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 rx_status  output  1  high while a frame is being received (any state except IDLE).

Function
REQ-014 rx_data passes through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-015 FSM states: IDLE, START, DATA, STOP, WRITE.
REQ-016 IDLE: on a synchronized high-to-low transition, go to START and clear the bit-cycle counter.
REQ-017 START: after CLKS_PER_BIT/2 cycles, sample the line; low goes to DATA, high (glitch) returns to IDLE with no output activity.
REQ-018 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the byte register; after bit 7 go to STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, sample; high goes to WRITE, low pulses frame_err, discards the byte, and returns to IDLE.
REQ-020 WRITE lasts exactly one cycle, then returns to IDLE. If write_mat=1, assert mem_we with mem_addr = current word count and mem_wdata = byte, then increment the count.
REQ-021 If write_mat=0 in WRITE, mem_we stays low and the byte is dropped silently.
REQ-022 When the count reaches DEPTH-1 and is written, the count wraps to 0 and load_done pulses on the next cycle.
REQ-023 While write_mat=0, the word count is held at 0 every cycle. A mid-load deassertion therefore restarts the next load at address 0 without a load_done pulse.
REQ-024 Back-to-back frames: a start edge arriving in the cycle after WRITE shall be detected; no frame is lost at full baud rate.
REQ-025 Latency: mem_we asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 (+/-1) cycles after the start edge on the pin.
REQ-026 mem_addr and mem_wdata are registered and hold their value between writes.
REQ-027 The bit-cycle counter is wide enough for CLKS_PER_BIT and never wraps within a bit period.

Reset
REQ-028 While rst=0, the FSM is in IDLE and count = 0, and the outputs are: mem_we=0, mem_addr=0, mem_wdata=0x00, load_done=0, frame_err=0, rx_status=0. Synchronizer flops reset to 1.
REQ-029 Reset asserted mid-frame aborts the frame with no write. After release, the block waits for a fresh falling edge and does not act on a line that is already low.

Verification (CLKS_PER_BIT=16, DEPTH=18)
REQ-030 Single byte: write_mat=1, send 0xA5 -> one mem_we pulse, addr=0, wdata=0xA5, frame_err=0.
REQ-031 Full load: send bytes 0x01..0x12 back-to-back -> 18 writes at addr 0..17 with matching data, one load_done pulse one cycle after the addr-17 write, next byte written at addr 0.
REQ-032 Framing error: send 0x3C with stop bit 0 -> frame_err pulses once, no mem_we, count unchanged; the next good byte 0x55 is written at the prior address.
REQ-033 Glitch: drive rx low for 4 cycles, then high -> return to IDLE, no mem_we, no frame_err.
REQ-034 Abort: drop write_mat after 5 bytes, then raise it and send 0x77 -> 0x77 is written at addr 0, no load_done.
REQ-035 Reset mid-frame: assert rst during DATA of byte 0x99 -> all outputs 0 immediately, no write; a subsequent byte 0x42 is written at addr 0.
